// File: rtl/audio_effect_engine_if.sv
// ============================================================================
// Module   : audio_effect_engine_if
// Brief    : CODEC read/write handshake and sample bus for the effect engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface audio_effect_engine_if #(
    parameter int DATA_W = 24
);
    logic              read_ready;
    logic [DATA_W-1:0] readdata_left;
    logic [DATA_W-1:0] readdata_right;
    logic              write_ready;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata_left;
    logic [DATA_W-1:0] writedata_right;
    logic              clip;

    modport master (
        input  read_ready, readdata_left, readdata_right, write_ready,
        output read, write, writedata_left, writedata_right, clip
    );

    modport slave (
        output read_ready, readdata_left, readdata_right, write_ready,
        input  read, write, writedata_left, writedata_right, clip
    );
endinterface

`default_nettype wire

// File: rtl/audio_effect_engine.sv
// ============================================================================
// Module   : audio_effect_engine
// Brief    : Stereo CODEC sample processor: passthrough, moving average, echo.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_effect_engine #(
    parameter int DATA_W     = 24,
    parameter int AVG_LOG2   = 3,
    parameter int DELAY_LOG2 = 12,
    parameter int ECHO_SHIFT = 1
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic [1:0]            mode,
    audio_effect_engine_if.master codec
);
    localparam int N_TAPS = 1 << AVG_LOG2;
    localparam int DEPTH  = 1 << DELAY_LOG2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ACK  = 3'd1,
        S_CALC = 3'd2,
        S_WAIT = 3'd3,
        S_WR   = 3'd4
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [1:0]               r_mode;
    logic [1:0][DATA_W-1:0]   r_x;
    logic [1:0][DATA_W-1:0]   r_y;
    logic [1:0][DATA_W-1:0]   w_y;
    logic [1:0]               w_clip;
    logic                     r_clip;
    logic [DELAY_LOG2-1:0]    r_ptr;
    logic [DELAY_LOG2:0]      r_fill;
    logic [2*DATA_W-1:0]      r_mem [DEPTH];
    logic [2*DATA_W-1:0]      r_ram_q;
    logic                     w_avg;
    logic                     w_echo;
    logic                     w_calc;

    assign w_avg  = (r_mode == 2'b01);
    assign w_echo = (r_mode == 2'b10);
    assign w_calc = (r_state == S_CALC);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        codec.read  = 1'b0;
        codec.write = 1'b0;
        codec.clip  = 1'b0;
        case (r_state)
            S_IDLE: if (codec.read_ready) w_next = S_ACK;
            S_ACK: begin
                codec.read = 1'b1;
                w_next     = S_CALC;
            end
            S_CALC: w_next = S_WAIT;
            S_WAIT: if (codec.write_ready) w_next = S_WR;
            S_WR: begin
                codec.write = 1'b1;
                codec.clip  = r_clip;
                w_next      = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_x    <= '0;
            r_mode <= '0;
            r_y    <= '0;
            r_clip <= 1'b0;
            r_ptr  <= '0;
            r_fill <= '0;
        end else begin
            if (r_state == S_IDLE && codec.read_ready) begin
                r_x[0] <= codec.readdata_left;
                r_x[1] <= codec.readdata_right;
                r_mode <= mode;
            end
            if (w_calc) begin
                r_y    <= w_y;
                r_clip <= |w_clip;
            end
            if (r_state == S_WR) begin
                r_ptr <= r_ptr + DELAY_LOG2'(1);
                if (!r_fill[DELAY_LOG2]) r_fill <= r_fill + (DELAY_LOG2+1)'(1);
            end
        end
    end

    // Read address is held stable from ACK, so the registered read is valid in CALC.
    always_ff @(posedge CLOCK_50) begin
        if (r_state == S_WR) r_mem[r_ptr] <= {r_y[1], r_y[0]};
        r_ram_q <= r_mem[r_ptr];
    end

    for (genvar c = 0; c < 2; c++) begin : g_chan
        logic signed [DATA_W-1:0]           w_xs;
        logic signed [DATA_W-1:0]           w_sum_next;
        logic signed [DATA_W-1:0]           w_d;
        logic signed [DATA_W-1:0]           w_dd;
        logic signed [DATA_W:0]             w_echo_sum;
        logic        [DATA_W-1:0]           w_y_c;
        logic                               w_clip_c;
        logic        [N_TAPS-1:0][DATA_W-1:0] r_hist;
        logic signed [DATA_W-1:0]           r_sum;

        assign w_xs       = $signed(r_x[c]) >>> AVG_LOG2;
        assign w_sum_next = r_sum + w_xs - $signed(r_hist[N_TAPS-1]);
        // Stale RAM contents are masked until every slot has been written once.
        assign w_d        = r_fill[DELAY_LOG2] ? $signed(r_ram_q[c*DATA_W +: DATA_W]) : '0;
        assign w_dd       = w_d >>> ECHO_SHIFT;
        assign w_echo_sum = $signed({r_x[c][DATA_W-1], r_x[c]}) + $signed({w_dd[DATA_W-1], w_dd});

        always_comb begin
            w_y_c    = r_x[c];
            w_clip_c = 1'b0;
            if (w_avg) begin
                w_y_c = w_sum_next;
            end else if (w_echo) begin
                if (w_echo_sum[DATA_W] != w_echo_sum[DATA_W-1]) begin
                    w_clip_c = 1'b1;
                    w_y_c    = w_echo_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                                  : {1'b0, {(DATA_W-1){1'b1}}};
                end else begin
                    w_y_c = w_echo_sum[DATA_W-1:0];
                end
            end
        end

        assign w_y[c]    = w_y_c;
        assign w_clip[c] = w_clip_c;

        always_ff @(posedge CLOCK_50 or negedge resetn) begin
            if (!resetn) begin
                r_hist <= '0;
                r_sum  <= '0;
            end else if (w_calc && w_avg) begin
                r_hist <= {r_hist[N_TAPS-2:0], w_xs};
                r_sum  <= w_sum_next;
            end
        end
    end

    assign codec.writedata_left  = r_y[0];
    assign codec.writedata_right = r_y[1];

endmodule

`default_nettype wire

// File: tb/tb_audio_effect_engine.sv
// ============================================================================
// Module   : tb_audio_effect_engine
// Brief    : Directed self-checking bench for audio_effect_engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_audio_effect_engine;
    logic       clk = 1'b0;
    logic       resetn;
    logic [1:0] mode;
    int         n_pass = 0;
    int         n_total = 0;

    audio_effect_engine_if #(.DATA_W(24)) bus ();

    audio_effect_engine #(
        .DATA_W    (24),
        .AVG_LOG2  (2),
        .DELAY_LOG2(3),
        .ECHO_SHIFT(1)
    ) dut (
        .CLOCK_50(clk),
        .resetn  (resetn),
        .mode    (mode),
        .codec   (bus)
    );

    always #5 clk = ~clk;

    logic [23:0] avg_in  [9] = '{24'h000400, 24'h000400, 24'h000400, 24'h000400, 24'h000400,
                                 24'hFFFC00, 24'hFFFC00, 24'hFFFC00, 24'hFFFC00};
    logic [23:0] avg_exp [9] = '{24'h000100, 24'h000200, 24'h000300, 24'h000400, 24'h000400,
                                 24'h000200, 24'h000000, 24'hFFFE00, 24'hFFFC00};

    task automatic do_reset();
        @(negedge clk);
        resetn          = 1'b0;
        bus.read_ready  = 1'b0;
        bus.write_ready = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    // One full sample transaction; ok=0 if no write appeared within the budget.
    task automatic xfer(input logic [23:0] l, input logic [23:0] r,
                        output logic [23:0] ol, output logic [23:0] orr,
                        output logic oc, output logic ok);
        ok = 1'b0; ol = '0; orr = '0; oc = 1'b0;
        bus.readdata_left  = l;
        bus.readdata_right = r;
        bus.read_ready     = 1'b1;
        bus.write_ready    = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.write) begin
                ol = bus.writedata_left; orr = bus.writedata_right; oc = bus.clip; ok = 1'b1;
                break;
            end
        end
        bus.read_ready  = 1'b0;
        bus.write_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        n_total += 5;
        if (bus.read !== 1'b0) $display("FAIL reset_read got=%b exp=0", bus.read); else n_pass++;
        if (bus.write !== 1'b0) $display("FAIL reset_write got=%b exp=0", bus.write); else n_pass++;
        if (bus.clip !== 1'b0) $display("FAIL reset_clip got=%b exp=0", bus.clip); else n_pass++;
        if (bus.writedata_left !== 24'h0) $display("FAIL reset_wdl got=%h exp=000000", bus.writedata_left); else n_pass++;
        if (bus.writedata_right !== 24'h0) $display("FAIL reset_wdr got=%h exp=000000", bus.writedata_right); else n_pass++;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_passthrough();
        int first_rd = -1, second_rd = -1, first_wr = -1, rd_early = 0, both = 0;
        logic [23:0] wl = '0, wr = '0;
        do_reset();
        mode = 2'b00;
        bus.readdata_left  = 24'h123456;
        bus.readdata_right = 24'hFEDCBA;
        bus.read_ready     = 1'b1;
        bus.write_ready    = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus.read && bus.write) both++;
            if (bus.read) begin
                if (first_rd < 0) first_rd = i;
                else if (second_rd < 0) second_rd = i;
                if (i <= 5) rd_early++;
            end
            if (bus.write && first_wr < 0) begin
                first_wr = i; wl = bus.writedata_left; wr = bus.writedata_right;
            end
        end
        bus.read_ready = 1'b0;
        n_total += 7;
        if (first_rd !== 1) $display("FAIL pt_read_cycle got=%0d exp=1", first_rd); else n_pass++;
        if (rd_early !== 1) $display("FAIL pt_read_count got=%0d exp=1", rd_early); else n_pass++;
        if (first_wr !== 4) $display("FAIL pt_write_cycle got=%0d exp=4", first_wr); else n_pass++;
        if (wl !== 24'h123456) $display("FAIL pt_left got=%h exp=123456", wl); else n_pass++;
        if (wr !== 24'hFEDCBA) $display("FAIL pt_right got=%h exp=fedcba", wr); else n_pass++;
        if (second_rd !== 6) $display("FAIL pt_next_read got=%0d exp=6", second_rd); else n_pass++;
        if (both !== 0) $display("FAIL pt_strobe_overlap got=%0d exp=0", both); else n_pass++;
    endtask

    task automatic test_average();
        logic [23:0] ol, orr;
        logic oc, ok;
        do_reset();
        mode = 2'b01;
        for (int i = 0; i < 9; i++) begin
            xfer(avg_in[i], avg_in[i], ol, orr, oc, ok);
            n_total++;
            if (!ok || ol !== avg_exp[i] || orr !== avg_exp[i] || oc !== 1'b0)
                $display("FAIL avg_sample%0d got=%h/%h clip=%b ok=%b exp=%h clip=0",
                         i, ol, orr, oc, ok, avg_exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_echo();
        logic [23:0] ol, orr, el, er;
        logic oc, ok;
        do_reset();
        mode = 2'b10;
        for (int i = 0; i < 17; i++) begin
            xfer((i == 0) ? 24'h400000 : 24'h0, (i == 0) ? 24'hC00000 : 24'h0, ol, orr, oc, ok);
            case (i)
                0:       begin el = 24'h400000; er = 24'hC00000; end
                8:       begin el = 24'h200000; er = 24'hE00000; end
                16:      begin el = 24'h100000; er = 24'hF00000; end
                default: begin el = 24'h0;      er = 24'h0;      end
            endcase
            n_total++;
            if (!ok || ol !== el || orr !== er || oc !== 1'b0)
                $display("FAIL echo_sample%0d got=%h/%h clip=%b ok=%b exp=%h/%h clip=0",
                         i, ol, orr, oc, ok, el, er);
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        logic [23:0] ol, orr, v;
        logic oc, ok;
        for (int p = 0; p < 2; p++) begin
            v = (p == 0) ? 24'h7FFFFF : 24'h800000;
            do_reset();
            mode = 2'b10;
            for (int i = 0; i < 9; i++) begin
                xfer(v, v, ol, orr, oc, ok);
                n_total++;
                if (!ok || ol !== v || orr !== v || oc !== (i == 8))
                    $display("FAIL sat_p%0d_sample%0d got=%h/%h clip=%b ok=%b exp=%h clip=%b",
                             p, i, ol, orr, oc, ok, v, (i == 8));
                else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] hl, hr;
        int got_rd = 0, bad_strobe = 0, bad_hold = 0;
        do_reset();
        mode = 2'b00;
        bus.readdata_left  = 24'h0ABCDE;
        bus.readdata_right = 24'h654321;
        bus.read_ready     = 1'b1;
        bus.write_ready    = 1'b0;
        for (int i = 0; i < 10 && got_rd == 0; i++) begin
            @(negedge clk);
            if (bus.read) got_rd = 1;
        end
        repeat (2) @(negedge clk);
        hl = bus.writedata_left;
        hr = bus.writedata_right;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.read || bus.write) bad_strobe++;
            if (bus.writedata_left !== hl || bus.writedata_right !== hr) bad_hold++;
        end
        bus.write_ready = 1'b1;
        @(negedge clk);
        n_total += 5;
        if (got_rd !== 1) $display("FAIL bp_read_seen got=%0d exp=1", got_rd); else n_pass++;
        if (hl !== 24'h0ABCDE || hr !== 24'h654321)
            $display("FAIL bp_data got=%h/%h exp=0abcde/654321", hl, hr);
        else n_pass++;
        if (bad_strobe !== 0) $display("FAIL bp_no_strobe got=%0d exp=0", bad_strobe); else n_pass++;
        if (bad_hold !== 0) $display("FAIL bp_hold got=%0d exp=0", bad_hold); else n_pass++;
        if (bus.write !== 1'b1) $display("FAIL bp_write_release got=%b exp=1", bus.write); else n_pass++;
        bus.read_ready  = 1'b0;
        bus.write_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [23:0] ol, orr, vl, vr;
        logic oc, ok;
        int got_rd = 0, wr_seen = 0;
        do_reset();
        mode = 2'b10;
        for (int i = 0; i < 20; i++) xfer(24'h001000 * i + 24'h1, 24'h0 - 24'h003000 * i, ol, orr, oc, ok);
        bus.readdata_left  = 24'h055555;
        bus.readdata_right = 24'h0AAAAA;
        bus.read_ready     = 1'b1;
        bus.write_ready    = 1'b0;
        for (int i = 0; i < 10 && got_rd == 0; i++) begin
            @(negedge clk);
            if (bus.read) got_rd = 1;
        end
        repeat (2) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        n_total += 4;
        if (got_rd !== 1) $display("FAIL mid_read_seen got=%0d exp=1", got_rd); else n_pass++;
        if (bus.writedata_left !== 24'h0 || bus.writedata_right !== 24'h0)
            $display("FAIL mid_async_data got=%h/%h exp=000000/000000", bus.writedata_left, bus.writedata_right);
        else n_pass++;
        if (bus.read !== 1'b0 || bus.write !== 1'b0 || bus.clip !== 1'b0)
            $display("FAIL mid_async_strobes got=%b%b%b exp=000", bus.read, bus.write, bus.clip);
        else n_pass++;
        bus.read_ready  = 1'b0;
        bus.write_ready = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.write) wr_seen++;
        end
        if (wr_seen !== 0) $display("FAIL mid_abandoned_write got=%0d exp=0", wr_seen); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            vl = 24'h010203 + 24'h001111 * i;
            vr = 24'hF00000 - 24'h000777 * i;
            xfer(vl, vr, ol, orr, oc, ok);
            n_total++;
            if (!ok || ol !== vl || orr !== vr || oc !== 1'b0)
                $display("FAIL mid_after_sample%0d got=%h/%h clip=%b ok=%b exp=%h/%h",
                         i, ol, orr, oc, ok, vl, vr);
            else n_pass++;
        end
    endtask

    initial begin
        resetn             = 1'b1;
        mode               = 2'b00;
        bus.read_ready     = 1'b0;
        bus.write_ready    = 1'b0;
        bus.readdata_left  = '0;
        bus.readdata_right = '0;
        test_reset();
        test_passthrough();
        test_average();
        test_echo();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
